// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_seq_pkg : state, opcode and ALU encodings for the datapath sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
package alu_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    DONE   = 3'd5
  } state_t;

  // Instruction class selects which EXEC/WB strobes fire.
  typedef enum logic [1:0] {K_ALU, K_LW, K_SW, K_BR} kind_t;

  typedef enum logic [1:0] {IMM_NONE, IMM_I, IMM_S, IMM_B} imm_sel_t;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_B  = 7'b1100011;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SLT = 4'd5;

endpackage
`default_nettype wire

// File: rtl/alu_datapath_sequencer_imm_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// imm_gen : combinational sign-extended I/S/B immediate extraction
// Rev 1.0
// ---------------------------------------------------------------------------
module imm_gen
  import alu_seq_pkg::*;
#(
  parameter int Data_Width = 32
) (
  input  logic [31:0]           instr,
  input  imm_sel_t              imm_sel,
  output logic [Data_Width-1:0] imm
);

  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[19:12], instr[6:0]};

  always_comb begin
    imm = '0;
    case (imm_sel)
      IMM_I:   imm = {{(Data_Width-12){instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{(Data_Width-12){instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{(Data_Width-13){instr[31]}}, instr[31], instr[7],
                      instr[30:25], instr[11:8], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_datapath_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_datapath_sequencer : multi-cycle RV32I control FSM for the regfile/ALU/RAM path
// Rev 1.0
// ---------------------------------------------------------------------------
module alu_datapath_sequencer
  import alu_seq_pkg::*;
#(
  parameter int Data_Width            = 32,
  parameter int Address_Width_RegFile = 5,
  parameter int Instr_Width           = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             instrValid,
  input  logic [Instr_Width-1:0]           instr,
  output logic                             instrReady,
  input  logic                             eq,
  output logic [Address_Width_RegFile-1:0] rs1,
  output logic [Address_Width_RegFile-1:0] rs2,
  output logic [Address_Width_RegFile-1:0] rd,
  output logic                             regFileWen,
  output logic                             ALUSrc,
  output logic [Data_Width-1:0]            ImmOp,
  output logic [3:0]                       ALU_ctrl,
  output logic                             MemWrite,
  output logic                             ResultSrc,
  output logic                             done,
  output logic                             branchTaken,
  output logic [Data_Width-1:0]            branchOffset,
  output logic                             illegal
);

  state_t                           state_q, state_d;
  logic [Instr_Width-1:0]           instr_q, instr_d;
  logic [Address_Width_RegFile-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [Data_Width-1:0]            imm_q, imm_d;
  logic [3:0]                       alu_ctrl_q, alu_ctrl_d;
  logic                             alu_src_q, alu_src_d;
  kind_t                            kind_q, kind_d;
  logic                             illegal_q, illegal_d;
  logic                             is_bne_q, is_bne_d;
  logic                             branch_taken_q, branch_taken_d;

  logic [6:0]                       opcode, funct7;
  logic [2:0]                       funct3;
  kind_t                            dec_kind;
  logic [3:0]                       dec_alu;
  logic                             dec_src, dec_ill;
  imm_sel_t                         dec_sel;
  logic [Address_Width_RegFile-1:0] dec_rs2, dec_rd;
  logic [Data_Width-1:0]            dec_imm;

  assign opcode = instr_q[6:0];
  assign funct3 = instr_q[14:12];
  assign funct7 = instr_q[31:25];

  imm_gen #(.Data_Width(Data_Width)) u_imm_gen (
    .instr   (instr_q),
    .imm_sel (dec_sel),
    .imm     (dec_imm)
  );

  // Unused register fields are zeroed so the address ports only show live operands.
  always_comb begin
    dec_kind = K_ALU;
    dec_alu  = ALU_ADD;
    dec_src  = 1'b0;
    dec_sel  = IMM_NONE;
    dec_ill  = 1'b0;
    dec_rs2  = instr_q[24:20];
    dec_rd   = instr_q[11:7];
    case (opcode)
      OP_R: begin
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000:  dec_alu = ALU_ADD;
            3'b111:  dec_alu = ALU_AND;
            3'b110:  dec_alu = ALU_OR;
            3'b010:  dec_alu = ALU_SLT;
            default: dec_ill = 1'b1;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          dec_alu = ALU_SUB;
        end else begin
          dec_ill = 1'b1;
        end
      end
      OP_I: begin
        dec_src = 1'b1;
        dec_sel = IMM_I;
        dec_rs2 = '0;
        case (funct3)
          3'b000:  dec_alu = ALU_ADD;
          3'b111:  dec_alu = ALU_AND;
          3'b110:  dec_alu = ALU_OR;
          default: dec_ill = 1'b1;
        endcase
      end
      OP_LW: begin
        dec_kind = K_LW;
        dec_src  = 1'b1;
        dec_sel  = IMM_I;
        dec_rs2  = '0;
        dec_ill  = (funct3 != 3'b010);
      end
      OP_SW: begin
        dec_kind = K_SW;
        dec_src  = 1'b1;
        dec_sel  = IMM_S;
        dec_rd   = '0;
        dec_ill  = (funct3 != 3'b010);
      end
      OP_B: begin
        dec_kind = K_BR;
        dec_alu  = ALU_SUB;
        dec_sel  = IMM_B;
        dec_rd   = '0;
        dec_ill  = (funct3 != 3'b000) && (funct3 != 3'b001);
      end
      default: dec_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    instr_d        = instr_q;
    rs1_d          = rs1_q;
    rs2_d          = rs2_q;
    rd_d           = rd_q;
    imm_d          = imm_q;
    alu_ctrl_d     = alu_ctrl_q;
    alu_src_d      = alu_src_q;
    kind_d         = kind_q;
    illegal_d      = illegal_q;
    is_bne_d       = is_bne_q;
    branch_taken_d = branch_taken_q;
    case (state_q)
      IDLE: begin
        if (instrValid) begin
          instr_d = instr;
          state_d = DECODE;
        end
      end
      DECODE: begin
        rs1_d          = instr_q[19:15];
        rs2_d          = dec_rs2;
        rd_d           = dec_rd;
        imm_d          = dec_imm;
        alu_ctrl_d     = dec_alu;
        alu_src_d      = dec_src;
        kind_d         = dec_kind;
        illegal_d      = dec_ill;
        is_bne_d       = funct3[0];
        branch_taken_d = 1'b0;
        state_d        = dec_ill ? DONE : EXEC;
      end
      EXEC: begin
        if (kind_q == K_BR) begin
          branch_taken_d = eq ^ is_bne_q;
        end
        state_d = (kind_q == K_LW) ? MEM : DONE;
      end
      MEM:     state_d = WB;
      WB:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      instr_q        <= '0;
      rs1_q          <= '0;
      rs2_q          <= '0;
      rd_q           <= '0;
      imm_q          <= '0;
      alu_ctrl_q     <= ALU_ADD;
      alu_src_q      <= 1'b0;
      kind_q         <= K_ALU;
      illegal_q      <= 1'b0;
      is_bne_q       <= 1'b0;
      branch_taken_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      instr_q        <= instr_d;
      rs1_q          <= rs1_d;
      rs2_q          <= rs2_d;
      rd_q           <= rd_d;
      imm_q          <= imm_d;
      alu_ctrl_q     <= alu_ctrl_d;
      alu_src_q      <= alu_src_d;
      kind_q         <= kind_d;
      illegal_q      <= illegal_d;
      is_bne_q       <= is_bne_d;
      branch_taken_q <= branch_taken_d;
    end
  end

  // Write strobes are qualified by rst_n so a reset landing mid-instruction never commits.
  assign instrReady   = rst_n && (state_q == IDLE);
  assign regFileWen   = rst_n && (rd_q != '0) &&
                        (((state_q == EXEC) && (kind_q == K_ALU)) || (state_q == WB));
  assign MemWrite     = rst_n && (state_q == EXEC) && (kind_q == K_SW);
  assign ResultSrc    = (state_q == WB);
  assign rs1          = rs1_q;
  assign rs2          = rs2_q;
  assign rd           = rd_q;
  assign ALUSrc       = alu_src_q;
  assign ImmOp        = imm_q;
  assign ALU_ctrl     = alu_ctrl_q;
  assign done         = (state_q == DONE);
  assign branchTaken  = done && branch_taken_q;
  assign branchOffset = (done && kind_q == K_BR) ? imm_q : '0;
  assign illegal      = done && illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_datapath_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_alu_datapath_sequencer : scoreboard bench for the RV32I control sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_alu_datapath_sequencer;

  logic        clk;
  logic        rst_n, instrValid, eq;
  logic [31:0] instr;
  logic        instrReady, regFileWen, ALUSrc, MemWrite, ResultSrc;
  logic        done, branchTaken, illegal;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] ImmOp, branchOffset;
  logic [3:0]  ALU_ctrl;

  typedef struct {
    int          lat;
    int          wen;
    int          wen_rs;
    int          mw;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic        asrc;
    logic        ill;
    logic        taken;
    logic [31:0] off;
  } exp_t;

  typedef struct {
    int          lat;
    int          wen;
    int          wen_rs;
    int          mw;
    int          busy_rdy;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic        asrc;
    logic        ill;
    logic        taken;
    logic [31:0] off;
    logic        done_after;
    logic        ready_after;
  } obs_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  alu_datapath_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instrValid   (instrValid),
    .instr        (instr),
    .instrReady   (instrReady),
    .eq           (eq),
    .rs1          (rs1),
    .rs2          (rs2),
    .rd           (rd),
    .regFileWen   (regFileWen),
    .ALUSrc       (ALUSrc),
    .ImmOp        (ImmOp),
    .ALU_ctrl     (ALU_ctrl),
    .MemWrite     (MemWrite),
    .ResultSrc    (ResultSrc),
    .done         (done),
    .branchTaken  (branchTaken),
    .branchOffset (branchOffset),
    .illegal      (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(int lat, int wen, int wen_rs, int mw, logic [4:0] rdv,
                              logic [31:0] imm, logic [3:0] alu, logic asrc,
                              logic ill, logic taken, logic [31:0] off);
    exp_t e;
    e.lat = lat; e.wen = wen; e.wen_rs = wen_rs; e.mw = mw; e.rd = rdv;
    e.imm = imm; e.alu = alu; e.asrc = asrc; e.ill = ill; e.taken = taken; e.off = off;
    return e;
  endfunction

  // Issues one instruction and records what the DUT does until done (bounded).
  task automatic run_instr(input logic [31:0] ins, input logic eq_in, output obs_t o);
    int waited;
    o = '{default: 0};
    waited = 0;
    @(negedge clk);
    while (!instrReady && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    instr = ins; instrValid = 1'b1; eq = eq_in;
    @(posedge clk);
    #1 instrValid = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 2) begin
        o.imm = ImmOp; o.alu = ALU_ctrl; o.asrc = ALUSrc;
      end
      if (instrReady) o.busy_rdy++;
      if (regFileWen) begin
        o.wen++;
        o.rd = rd;
        if (ResultSrc) o.wen_rs++;
      end
      if (MemWrite) o.mw++;
      if (done) begin
        o.lat = c; o.ill = illegal; o.taken = branchTaken; o.off = branchOffset;
        break;
      end
    end
    @(negedge clk);
    o.done_after  = done;
    o.ready_after = instrReady;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; instrValid = 1'b0; instr = '0; eq = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++; if (instrReady !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", instrReady); end
    n_tests++; if ({regFileWen, MemWrite, done} !== 3'b000) begin n_fail++; $display("FAIL reset_strobes: got %b want 000", {regFileWen, MemWrite, done}); end
    n_tests++; if ({rs1, rs2, rd} !== 15'd0) begin n_fail++; $display("FAIL reset_regaddr: got %h want 0", {rs1, rs2, rd}); end
    n_tests++; if (ImmOp !== 32'd0 || ALU_ctrl !== 4'd0) begin n_fail++; $display("FAIL reset_imm_alu: got %h/%h want 0/0", ImmOp, ALU_ctrl); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_tests++; if (instrReady !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", instrReady); end
  endtask

  task automatic test_alu();
    logic [31:0] ins [6];
    obs_t o;
    exp_t e;
    ins = '{32'h00700293, 32'h402081B3, 32'h0020F233, 32'h0020A3B3, 32'hFFF0E413, 32'h00208033};
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: sb.push_back(mk(3, 1, 0, 0, 5'd5, 32'd7,        4'd0, 1'b1, 1'b0, 1'b0, 32'd0));
        1: sb.push_back(mk(3, 1, 0, 0, 5'd3, 32'd0,        4'd1, 1'b0, 1'b0, 1'b0, 32'd0));
        2: sb.push_back(mk(3, 1, 0, 0, 5'd4, 32'd0,        4'd2, 1'b0, 1'b0, 1'b0, 32'd0));
        3: sb.push_back(mk(3, 1, 0, 0, 5'd7, 32'd0,        4'd5, 1'b0, 1'b0, 1'b0, 32'd0));
        4: sb.push_back(mk(3, 1, 0, 0, 5'd8, 32'hFFFFFFFF, 4'd3, 1'b1, 1'b0, 1'b0, 32'd0));
        default: sb.push_back(mk(3, 0, 0, 0, 5'd0, 32'd0,  4'd0, 1'b0, 1'b0, 1'b0, 32'd0));
      endcase
      run_instr(ins[i], 1'b0, o);
      e = sb.pop_front();
      n_tests++; if (o.lat != e.lat) begin n_fail++; $display("FAIL alu%0d_latency: got %0d want %0d", i, o.lat, e.lat); end
      n_tests++; if (o.wen != e.wen || o.wen_rs != 0) begin n_fail++; $display("FAIL alu%0d_wen: got %0d (rs %0d) want %0d (rs 0)", i, o.wen, o.wen_rs, e.wen); end
      if (e.wen > 0) begin
        n_tests++; if (o.rd !== e.rd) begin n_fail++; $display("FAIL alu%0d_rd: got %0d want %0d", i, o.rd, e.rd); end
      end
      n_tests++; if (o.mw != 0) begin n_fail++; $display("FAIL alu%0d_memwrite: got %0d want 0", i, o.mw); end
      n_tests++; if (o.imm !== e.imm || o.asrc !== e.asrc) begin n_fail++; $display("FAIL alu%0d_imm_src: got %h/%b want %h/%b", i, o.imm, o.asrc, e.imm, e.asrc); end
      n_tests++; if (o.alu !== e.alu) begin n_fail++; $display("FAIL alu%0d_ctrl: got %0d want %0d", i, o.alu, e.alu); end
      n_tests++; if (o.ill !== e.ill) begin n_fail++; $display("FAIL alu%0d_illegal: got %b want %b", i, o.ill, e.ill); end
      n_tests++; if (o.busy_rdy != 0 || o.done_after !== 1'b0 || o.ready_after !== 1'b1) begin
        n_fail++; $display("FAIL alu%0d_handshake: busy_ready %0d done_after %b ready_after %b want 0/0/1", i, o.busy_rdy, o.done_after, o.ready_after);
      end
    end
  endtask

  task automatic test_load();
    obs_t o;
    exp_t e;
    sb.push_back(mk(5, 1, 1, 0, 5'd6, 32'd8, 4'd0, 1'b1, 1'b0, 1'b0, 32'd0));
    run_instr(32'h0082A303, 1'b0, o);
    e = sb.pop_front();
    n_tests++; if (o.lat != e.lat) begin n_fail++; $display("FAIL lw_latency: got %0d want %0d", o.lat, e.lat); end
    n_tests++; if (o.wen != e.wen || o.wen_rs != e.wen_rs) begin n_fail++; $display("FAIL lw_writeback: got wen %0d rs %0d want %0d/%0d", o.wen, o.wen_rs, e.wen, e.wen_rs); end
    n_tests++; if (o.rd !== e.rd) begin n_fail++; $display("FAIL lw_rd: got %0d want %0d", o.rd, e.rd); end
    n_tests++; if (o.imm !== e.imm || o.asrc !== e.asrc || o.alu !== e.alu) begin n_fail++; $display("FAIL lw_addr_ctrl: got %h/%b/%0d want %h/%b/%0d", o.imm, o.asrc, o.alu, e.imm, e.asrc, e.alu); end
  endtask

  task automatic test_store();
    obs_t o;
    exp_t e;
    sb.push_back(mk(3, 0, 0, 1, 5'd0, 32'hFFFFFFFC, 4'd0, 1'b1, 1'b0, 1'b0, 32'd0));
    run_instr(32'hFE62AE23, 1'b0, o);
    e = sb.pop_front();
    n_tests++; if (o.lat != e.lat) begin n_fail++; $display("FAIL sw_latency: got %0d want %0d", o.lat, e.lat); end
    n_tests++; if (o.mw != e.mw) begin n_fail++; $display("FAIL sw_memwrite: got %0d cycles want %0d", o.mw, e.mw); end
    n_tests++; if (o.wen != e.wen) begin n_fail++; $display("FAIL sw_no_regwrite: got %0d want %0d", o.wen, e.wen); end
    n_tests++; if (o.imm !== e.imm || o.asrc !== e.asrc) begin n_fail++; $display("FAIL sw_imm: got %h/%b want %h/%b", o.imm, o.asrc, e.imm, e.asrc); end
  endtask

  task automatic test_branch();
    logic [31:0] ins [4];
    logic        eqs [4];
    obs_t o;
    exp_t e;
    ins = '{32'h00208863, 32'h00209863, 32'hFE208CE3, 32'hFE209CE3};
    eqs = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: sb.push_back(mk(3, 0, 0, 0, 5'd0, 32'd16,       4'd1, 1'b0, 1'b0, 1'b1, 32'd16));
        1: sb.push_back(mk(3, 0, 0, 0, 5'd0, 32'd16,       4'd1, 1'b0, 1'b0, 1'b0, 32'd16));
        2: sb.push_back(mk(3, 0, 0, 0, 5'd0, 32'hFFFFFFF8, 4'd1, 1'b0, 1'b0, 1'b0, 32'hFFFFFFF8));
        default: sb.push_back(mk(3, 0, 0, 0, 5'd0, 32'hFFFFFFF8, 4'd1, 1'b0, 1'b0, 1'b1, 32'hFFFFFFF8));
      endcase
      run_instr(ins[i], eqs[i], o);
      e = sb.pop_front();
      n_tests++; if (o.lat != e.lat) begin n_fail++; $display("FAIL br%0d_latency: got %0d want %0d", i, o.lat, e.lat); end
      n_tests++; if (o.taken !== e.taken) begin n_fail++; $display("FAIL br%0d_taken: got %b want %b", i, o.taken, e.taken); end
      n_tests++; if (o.off !== e.off) begin n_fail++; $display("FAIL br%0d_offset: got %h want %h", i, o.off, e.off); end
      n_tests++; if (o.alu !== e.alu || o.asrc !== e.asrc) begin n_fail++; $display("FAIL br%0d_alu: got %0d/%b want %0d/%b", i, o.alu, o.asrc, e.alu, e.asrc); end
      n_tests++; if (o.wen != 0 || o.mw != 0) begin n_fail++; $display("FAIL br%0d_no_write: got wen %0d mw %0d want 0/0", i, o.wen, o.mw); end
    end
  endtask

  task automatic test_illegal();
    logic [31:0] ins [2];
    obs_t o;
    exp_t e;
    ins = '{32'h0000007F, 32'h02208033};
    for (int i = 0; i < 2; i++) begin
      sb.push_back(mk(2, 0, 0, 0, 5'd0, 32'd0, 4'd0, 1'b0, 1'b1, 1'b0, 32'd0));
      run_instr(ins[i], 1'b0, o);
      e = sb.pop_front();
      n_tests++; if (o.lat != e.lat) begin n_fail++; $display("FAIL ill%0d_latency: got %0d want %0d", i, o.lat, e.lat); end
      n_tests++; if (o.ill !== e.ill) begin n_fail++; $display("FAIL ill%0d_flag: got %b want %b", i, o.ill, e.ill); end
      n_tests++; if (o.wen != 0 || o.mw != 0) begin n_fail++; $display("FAIL ill%0d_no_write: got wen %0d mw %0d want 0/0", i, o.wen, o.mw); end
      n_tests++; if (o.ready_after !== 1'b1) begin n_fail++; $display("FAIL ill%0d_ready_after: got %b want 1", i, o.ready_after); end
    end
  endtask

  task automatic test_back_to_back();
    obs_t o1, o2;
    exp_t e1, e2;
    sb.push_back(mk(3, 1, 0, 0, 5'd5, 32'd7, 4'd0, 1'b1, 1'b0, 1'b0, 32'd0));
    run_instr(32'h00700293, 1'b0, o1);
    sb.push_back(mk(5, 1, 1, 0, 5'd6, 32'd8, 4'd0, 1'b1, 1'b0, 1'b0, 32'd0));
    run_instr(32'h0082A303, 1'b0, o2);
    e1 = sb.pop_front();
    e2 = sb.pop_front();
    n_tests++; if (o1.lat != e1.lat || o1.rd !== e1.rd) begin n_fail++; $display("FAIL b2b_first: got lat %0d rd %0d want %0d/%0d", o1.lat, o1.rd, e1.lat, e1.rd); end
    n_tests++; if (o2.lat != e2.lat || o2.wen_rs != e2.wen_rs) begin n_fail++; $display("FAIL b2b_second: got lat %0d wb %0d want %0d/%0d", o2.lat, o2.wen_rs, e2.lat, e2.wen_rs); end
  endtask

  task automatic test_reset_mid();
    int dones;
    dones = 0;
    @(negedge clk);
    instr = 32'hFE62AE23; instrValid = 1'b1; eq = 1'b0;
    @(posedge clk);
    #1 instrValid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    n_tests++; if (MemWrite !== 1'b0) begin n_fail++; $display("FAIL rstmid_memwrite: got %b want 0", MemWrite); end
    n_tests++; if (regFileWen !== 1'b0) begin n_fail++; $display("FAIL rstmid_regwen: got %b want 0", regFileWen); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_tests++; if (instrReady !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b want 1", instrReady); end
    repeat (6) begin
      @(negedge clk);
      if (done) dones++;
    end
    n_tests++; if (dones != 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d pulses want 0", dones); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_branch();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire
